// File: rtl/fm_avalon_master.sv
// Internal req/ack to Avalon-MM master bridge with pipelined read returns.
// Optional waitrequest timeout: define FM_AVM_TIMEOUT_EN.
module fm_avalon_master #(
    parameter int P_ADR_WIDTH       = 24,
    parameter int P_BE_WIDTH        = 4,
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_TIMEOUT         = 1024
) (
    input  logic                    clk_core,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic                    i_wr,
    input  logic [P_ADR_WIDTH-1:0]  i_adrs,
    input  logic [P_BE_WIDTH-1:0]   i_be,
    input  logic [P_DATA_WIDTH-1:0] i_wd,
    output logic                    o_ack,
    output logic                    o_rstr,
    output logic [P_DATA_WIDTH-1:0] o_rd,
    output logic                    o_idle,
    output logic                    o_timeout,
    output logic [P_ADR_WIDTH-1:0]  o_av_adr,
    output logic [P_BE_WIDTH-1:0]   o_av_be,
    output logic                    o_av_r,
    output logic                    o_av_w,
    output logic [P_DATA_WIDTH-1:0] o_av_wd,
    input  logic                    i_av_wait,
    input  logic [P_DATA_WIDTH-1:0] i_av_rd,
    input  logic                    i_av_rdv
);

    localparam int CW = 4;
    localparam logic [CW-1:0] MAXC = CW'(P_MAX_OUTSTANDING);
    localparam logic [P_DATA_WIDTH-1:0] TO_DATA =
        P_DATA_WIDTH'(32'hDEAD_BEEF);

    typedef enum logic {
        S_IDLE,
        S_CMD
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          cap;
    logic          acc;
    logic          inc;
    logic          dec;
    logic          to_hit;
    logic          to_rd;
    logic          ack_nx;
    logic          av_r_nx;
    logic          av_w_nx;

`ifdef FM_AVM_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(P_TIMEOUT - 1);

    logic [TW-1:0] tmr;
    logic          to_flag;

    assign to_hit    = (state == S_CMD) & i_av_wait & (tmr == TLAST);
    assign o_timeout = to_flag;

    // Cycles spent in CMD; cleared whenever the bridge is idle
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (state != S_CMD) begin
            tmr <= '0;
        end else if (tmr != TLAST) begin
            tmr <= tmr + TW'(1);
        end
    end

    // Sticky timeout flag, only reset clears it
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            to_flag <= 1'b0;
        end else if (to_hit) begin
            to_flag <= 1'b1;
        end
    end
`else
    logic unused_to;

    assign unused_to = ^P_TIMEOUT;
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign to_rd = to_hit & o_av_r;

    // Next-state, command and outstanding-count logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ack_nx   = 1'b0;
        av_r_nx  = o_av_r;
        av_w_nx  = o_av_w;
        cap      = 1'b0;
        acc      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_req && (i_wr || (cnt < MAXC))) begin
                    cap      = 1'b1;
                    ack_nx   = 1'b1;
                    av_r_nx  = !i_wr;
                    av_w_nx  = i_wr;
                    state_nx = S_CMD;
                end
            end
            S_CMD: begin
                if (!i_av_wait || to_hit) begin
                    acc      = !i_av_wait;
                    av_r_nx  = 1'b0;
                    av_w_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
            end
        endcase
        inc = acc & o_av_r;
        dec = i_av_rdv & ((cnt != '0) | inc);
        if (inc && !dec) begin
            cnt_nx = cnt + CW'(1);
        end else if (dec && !inc) begin
            cnt_nx = cnt - CW'(1);
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            o_ack    <= 1'b0;
            o_av_r   <= 1'b0;
            o_av_w   <= 1'b0;
            o_av_adr <= '0;
            o_av_be  <= '0;
            o_av_wd  <= '0;
            o_idle   <= 1'b1;
            o_rstr   <= 1'b0;
            o_rd     <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            o_ack  <= ack_nx;
            o_av_r <= av_r_nx;
            o_av_w <= av_w_nx;
            if (cap) begin
                o_av_adr <= i_adrs;
                o_av_be  <= i_be;
                o_av_wd  <= i_wd;
            end
            o_idle <= (state_nx == S_IDLE) && (cnt_nx == '0);
            o_rstr <= i_av_rdv | to_rd;
            if (to_rd) begin
                o_rd <= TO_DATA;
            end else if (i_av_rdv) begin
                o_rd <= i_av_rd;
            end
        end
    end

endmodule

// File: tb/tb_fm_avalon_master.sv
// Bench for fm_avalon_master: vector table, corner sequences, read scoreboard.
// Timeout sequence runs only when FM_AVM_TIMEOUT_EN is defined.
module tb_fm_avalon_master;

    logic        clk_core;
    logic        rst;
    logic        i_req;
    logic        i_wr;
    logic [23:0] i_adrs;
    logic [3:0]  i_be;
    logic [31:0] i_wd;
    logic        o_ack;
    logic        o_rstr;
    logic [31:0] o_rd;
    logic        o_idle;
    logic        o_timeout;
    logic [23:0] o_av_adr;
    logic [3:0]  o_av_be;
    logic        o_av_r;
    logic        o_av_w;
    logic [31:0] o_av_wd;
    logic        i_av_wait;
    logic [31:0] i_av_rd;
    logic        i_av_rdv;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [23:0] adr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        idle2;
    } vec_t;

    vec_t tbl[5];

    fm_avalon_master #(
        .P_ADR_WIDTH(24),
        .P_BE_WIDTH(4),
        .P_DATA_WIDTH(32),
        .P_MAX_OUTSTANDING(4),
        .P_TIMEOUT(8)
    ) dut (
        .clk_core(clk_core),
        .rst(rst),
        .i_req(i_req),
        .i_wr(i_wr),
        .i_adrs(i_adrs),
        .i_be(i_be),
        .i_wd(i_wd),
        .o_ack(o_ack),
        .o_rstr(o_rstr),
        .o_rd(o_rd),
        .o_idle(o_idle),
        .o_timeout(o_timeout),
        .o_av_adr(o_av_adr),
        .o_av_be(o_av_be),
        .o_av_r(o_av_r),
        .o_av_w(o_av_w),
        .o_av_wd(o_av_wd),
        .i_av_wait(i_av_wait),
        .i_av_rd(i_av_rd),
        .i_av_rdv(i_av_rdv)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_idle"}, o_idle, 1);
        chk({tag, "_ack"}, o_ack, 0);
        chk({tag, "_rstr"}, o_rstr, 0);
        chk({tag, "_rd"}, o_rd, 0);
        chk({tag, "_to"}, o_timeout, 0);
        chk({tag, "_r"}, o_av_r, 0);
        chk({tag, "_w"}, o_av_w, 0);
        chk({tag, "_adr"}, o_av_adr, 0);
        chk({tag, "_be"}, o_av_be, 0);
        chk({tag, "_wd"}, o_av_wd, 0);
    endtask

    task automatic drive_req(input logic wr, input logic [23:0] adr,
                             input logic [3:0] be, input logic [31:0] wd);
        i_req  = 1'b1;
        i_wr   = wr;
        i_adrs = adr;
        i_be   = be;
        i_wd   = wd;
    endtask

    task automatic ret(input logic [31:0] d);
        i_av_rdv = 1'b1;
        i_av_rd  = d;
        exp_q.push_back(d);
    endtask

    // Read-return scoreboard: every strobe must match the oldest expected word
    always @(posedge clk_core) begin
        #2;
        if (o_rstr) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rstr_unexp: got strobe data %0h want none",
                         o_rd);
            end else begin
                chk("rd_data", o_rd, exp_q.pop_front());
            end
        end
    end

    initial begin
        tbl[0] = '{1'b1, 24'h000010, 4'hF, 32'h12345678, 32'h0, 1'b1};
        tbl[1] = '{1'b0, 24'h000030, 4'hF, 32'h0, 32'h5555AAAA, 1'b0};
        tbl[2] = '{1'b1, 24'hFFFFFF, 4'h5, 32'hDEADBEEF, 32'h0, 1'b1};
        tbl[3] = '{1'b0, 24'h000001, 4'h3, 32'h0, 32'h00C0FFEE, 1'b0};
        tbl[4] = '{1'b1, 24'h000000, 4'h0, 32'h0, 32'h0, 1'b1};

        rst       = 1'b1;
        i_req     = 1'b0;
        i_wr      = 1'b0;
        i_adrs    = '0;
        i_be      = '0;
        i_wd      = '0;
        i_av_wait = 1'b0;
        i_av_rd   = '0;
        i_av_rdv  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_rst_vals("rst0");

        // reset in the middle of a stalled write
        i_av_wait = 1'b1;
        drive_req(1'b1, 24'h000055, 4'hF, 32'h0BADF00D);
        tick();
        chk("mid_w_set", o_av_w, 1);
        rst = 1'b1;
        #1;
        chk("mid_w_async", o_av_w, 0);
        chk("mid_idle", o_idle, 1);
        i_req     = 1'b0;
        i_av_wait = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_rst_vals("rst1");

        // single transfers, no wait
        for (int i = 0; i < 5; i++) begin
            drive_req(tbl[i].wr, tbl[i].adr, tbl[i].be, tbl[i].wd);
            tick();
            chk("v_ack", o_ack, 1);
            chk("v_w", o_av_w, tbl[i].wr);
            chk("v_r", o_av_r, !tbl[i].wr);
            chk("v_adr", o_av_adr, tbl[i].adr);
            chk("v_be", o_av_be, tbl[i].be);
            if (tbl[i].wr) chk("v_wd", o_av_wd, tbl[i].wd);
            chk("v_idle1", o_idle, 0);
            i_req = 1'b0;
            tick();
            chk("v_ack2", o_ack, 0);
            chk("v_w2", o_av_w, 0);
            chk("v_r2", o_av_r, 0);
            chk("v_idle2", o_idle, tbl[i].idle2);
            if (!tbl[i].wr) begin
                ret(tbl[i].rd);
                tick();
                i_av_rdv = 1'b0;
                chk("v_idle3", o_idle, 1);
            end
        end

        // waitrequest stall on a read
        i_av_wait = 1'b1;
        drive_req(1'b0, 24'h000020, 4'hF, 32'h0);
        tick();
        i_req = 1'b0;
        chk("st_ack", o_ack, 1);
        for (int i = 0; i < 6; i++) begin
            chk("st_r", o_av_r, 1);
            chk("st_adr", o_av_adr, 24'h000020);
            if (i == 1) chk("st_ack0", o_ack, 0);
            if (i == 5) i_av_wait = 1'b0;
            tick();
        end
        chk("st_r_done", o_av_r, 0);
        chk("st_idle_busy", o_idle, 0);
        ret(32'h20202020);
        tick();
        i_av_rdv = 1'b0;
        tick();
        chk("st_idle_end", o_idle, 1);

        // pipelined reads up to the outstanding limit
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b0, 24'h000100 + 24'(k), 4'hF, 32'h0);
            tick();
            chk("pl_ack", o_ack, 1);
            chk("pl_adr", o_av_adr, 24'h000100 + 24'(k));
            i_req = 1'b0;
            tick();
        end
        chk("pl_idle_full", o_idle, 0);
        drive_req(1'b0, 24'h000104, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pl_stall_ack", o_ack, 0);
            chk("pl_stall_r", o_av_r, 0);
        end
        ret(32'h000000A0);
        tick();
        i_av_rdv = 1'b0;
        chk("pl_ack_late", o_ack, 0);
        tick();
        chk("pl_ack5", o_ack, 1);
        chk("pl_adr5", o_av_adr, 24'h000104);
        i_req = 1'b0;
        ret(32'h000000A1);
        tick();
        ret(32'h000000A2);
        tick();
        ret(32'h000000A3);
        tick();
        chk("pl_idle_one", o_idle, 0);
        ret(32'h000000A4);
        tick();
        i_av_rdv = 1'b0;
        tick();
        chk("pl_idle_end", o_idle, 1);

        // spurious readdatavalid with nothing outstanding
        ret(32'hCAFE0000);
        tick();
        i_av_rdv = 1'b0;
        chk("sp_idle", o_idle, 1);
        tick();
        chk("sp_idle2", o_idle, 1);
        drive_req(1'b1, 24'h000077, 4'hF, 32'h77777777);
        tick();
        i_req = 1'b0;
        tick();
        chk("sp_idle3", o_idle, 1);

`ifdef FM_AVM_TIMEOUT_EN
        // read that never gets past waitrequest
        i_av_wait = 1'b1;
        drive_req(1'b0, 24'h000040, 4'hF, 32'h0);
        tick();
        i_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_r", o_av_r, 1);
            chk("to_flag0", o_timeout, 0);
            if (i == 7) exp_q.push_back(32'hDEADBEEF);
            tick();
        end
        chk("to_r_drop", o_av_r, 0);
        chk("to_flag", o_timeout, 1);
        chk("to_idle", o_idle, 1);
        i_av_wait = 1'b0;
        tick();
        chk("to_sticky", o_timeout, 1);
`else
        chk("no_to", o_timeout, 0);
`endif

        repeat (3) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
